// File: rtl/tile_fill_engine_pkg.sv
// tile_fill_engine_pkg: register map, control/status bit positions, FSM
// encoding and tile-map geometry shared by the fill engine and its
// configuration slave.
package tile_fill_engine_pkg;

  // Tile map geometry; the fill rectangle wraps at these edges.
  localparam int MAP_W   = 64;
  localparam int MAP_H   = 64;
  localparam int COORD_W = $clog2(MAP_W);
  localparam int ROW_W   = $clog2(MAP_H);

  // Register word indices (cfg_addr[3:2]).
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RECT   = 2'd1;
  localparam logic [1:0] REG_VALUE  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_START      = 0;
  localparam int CTRL_WAIT_VSYNC = 1;
  localparam int CTRL_ABORT      = 2;

  // STATUS bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_FINISH  = 2'd3
  } fill_state_t;

  // Fill rectangle as held in the RECT register (fields only, no padding).
  typedef struct packed {
    logic [6:0] h;
    logic [6:0] w;
    logic [5:0] y0;
    logic [5:0] x0;
  } rect_t;

  // Word offset of a tile cell inside the tile memory window: row in the
  // upper field, column in the lower field.
  function automatic logic [11:0] cell_word(input logic [5:0] x, input logic [5:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/tile_fill_cfg_regs.sv
// tile_fill_cfg_regs: CPU register slave for the tile fill engine.
// Decodes accesses, holds CTRL/RECT/VALUE/STATUS and produces the
// single-cycle START/ABORT requests consumed by the fill FSM.
module tile_fill_cfg_regs
  import tile_fill_engine_pkg::*;
#(
  parameter logic [31:0] CFG_BASE = 32'h0540_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_addr,
  input  logic [3:0]  cfg_wstrb,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_ready,
  input  logic        busy,
  input  logic        done_set,
  input  logic        aborted_set,
  output logic        start_req,
  output logic        abort_req,
  output logic        wait_vsync_eff,
  output rect_t       rect,
  output logic [5:0]  value,
  output logic        done,
  output logic        aborted
);

  logic        accept;
  logic        hit;
  logic        is_write;
  logic [1:0]  idx;
  logic        wr_ctrl_b0;
  logic        wr_rect;
  logic        wr_value;
  logic        clr_status;
  logic        wait_vsync;
  logic [31:0] rd_mux;
  logic        unused_cfg_bits;

  // An access is taken only while cfg_ready is low, so a request held
  // across the acknowledge cycle is not accepted twice.
  assign accept   = cfg_valid & ~cfg_ready;
  assign hit      = (cfg_addr[31:4] == CFG_BASE[31:4]);
  assign is_write = |cfg_wstrb;
  assign idx      = cfg_addr[3:2];

  assign wr_ctrl_b0 = accept & hit & is_write & (idx == REG_CTRL) & cfg_wstrb[0];
  assign wr_rect    = accept & hit & is_write & (idx == REG_RECT) & ~busy;
  assign wr_value   = accept & hit & is_write & (idx == REG_VALUE) & ~busy & cfg_wstrb[0];
  assign clr_status = accept & hit & is_write & (idx == REG_STATUS) & cfg_wstrb[0]
                      & cfg_wdata[STAT_DONE];

  // START is dropped while a fill is running; ABORT is always forwarded.
  assign start_req = wr_ctrl_b0 & cfg_wdata[CTRL_START] & ~busy;
  assign abort_req = wr_ctrl_b0 & cfg_wdata[CTRL_ABORT];

  // A single CTRL write may set WAIT_VSYNC and START together, so the FSM
  // sees the value being written rather than the stale register.
  assign wait_vsync_eff = wr_ctrl_b0 ? cfg_wdata[CTRL_WAIT_VSYNC] : wait_vsync;

  // Data bits that no register implements.
  assign unused_cfg_bits = ^{cfg_addr[1:0], cfg_wdata[7:6], cfg_wdata[15:14],
                             cfg_wdata[23], cfg_wdata[31]};

  // Read mux over the four word registers.
  always_comb begin
    rd_mux = 32'd0;
    case (idx)
      REG_CTRL:   rd_mux[CTRL_WAIT_VSYNC] = wait_vsync;
      REG_RECT:   rd_mux = {1'b0, rect.h, 1'b0, rect.w, 2'b00, rect.y0, 2'b00, rect.x0};
      REG_VALUE:  rd_mux = {26'd0, value};
      REG_STATUS: rd_mux = {29'd0, aborted, done, busy};
      default:    rd_mux = 32'd0;
    endcase
  end

  // Acknowledge pulse and registered read data for the access just taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      cfg_rdata <= 32'd0;
    end else begin
      cfg_ready <= accept;
      cfg_rdata <= (accept & hit & ~is_write) ? rd_mux : 32'd0;
    end
  end

  // Configuration registers; RECT and VALUE are frozen while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_vsync <= 1'b0;
      rect       <= '0;
      value      <= 6'd0;
    end else begin
      if (wr_ctrl_b0) wait_vsync <= cfg_wdata[CTRL_WAIT_VSYNC];
      if (wr_rect) begin
        if (cfg_wstrb[0]) rect.x0 <= cfg_wdata[5:0];
        if (cfg_wstrb[1]) rect.y0 <= cfg_wdata[13:8];
        if (cfg_wstrb[2]) rect.w  <= cfg_wdata[22:16];
        if (cfg_wstrb[3]) rect.h  <= cfg_wdata[30:24];
      end
      if (wr_value) value <= cfg_wdata[5:0];
    end
  end

  // Sticky status flags; a set from the engine beats a CPU clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= done_set    | (done    & ~clr_status);
      aborted <= aborted_set | (aborted & ~clr_status);
    end
  end

endmodule

// File: rtl/tile_fill_engine.sv
// tile_fill_engine: iomem initiator that writes one tile index into every
// cell of a programmed rectangle of the 64x64 tile map, optionally waiting
// for vertical sync before starting.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no fill in progress; waiting for START
// WAIT_VS  | fill armed, waiting for the asserting edge of vsync
// ISSUE    | m_valid high for cell (cx,cy); advance on m_ready
// FINISH   | one cycle; set DONE (and ABORTED if aborted), back to IDLE
module tile_fill_engine
  import tile_fill_engine_pkg::*;
#(
  parameter logic [31:0] CFG_BASE         = 32'h0540_0000,
  parameter logic [31:0] TILE_BASE        = 32'h0520_0000,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_addr,
  input  logic [3:0]  cfg_wstrb,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_ready,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        vsync,
  output logic        irq
);

  fill_state_t        state, state_nxt;
  logic [6:0]         cx, cx_nxt;
  logic [6:0]         cy, cy_nxt;
  logic               abort_pend, abort_pend_nxt;
  logic               done_set, aborted_set;
  logic               busy;
  logic               start_req, abort_req, wait_vsync_eff;
  rect_t              rect;
  logic [5:0]         value;
  logic               done, aborted;
  logic               vs_act, vs_q, vs_edge;
  logic               cx_last, cy_last;
  logic [COORD_W-1:0] cell_x;
  logic [ROW_W-1:0]   cell_y;

  tile_fill_cfg_regs #(
    .CFG_BASE(CFG_BASE)
  ) u_regs (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_addr      (cfg_addr),
    .cfg_wstrb     (cfg_wstrb),
    .cfg_wdata     (cfg_wdata),
    .cfg_rdata     (cfg_rdata),
    .cfg_ready     (cfg_ready),
    .busy          (busy),
    .done_set      (done_set),
    .aborted_set   (aborted_set),
    .start_req     (start_req),
    .abort_req     (abort_req),
    .wait_vsync_eff(wait_vsync_eff),
    .rect          (rect),
    .value         (value),
    .done          (done),
    .aborted       (aborted)
  );

  // vsync shares clk, so one register is enough for edge detection.
  assign vs_act  = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign vs_edge = vs_act & ~vs_q;

  assign cx_last = ((cx + 7'd1) == rect.w);
  assign cy_last = ((cy + 7'd1) == rect.h);

  // Column/row arithmetic is modulo the map size, giving edge wrap for free.
  assign cell_x = rect.x0 + cx[COORD_W-1:0];
  assign cell_y = rect.y0 + cy[ROW_W-1:0];

  assign busy = (state != ST_IDLE);
  assign irq  = done;

  // Bus outputs are decoded from state so an asynchronous reset clears
  // them immediately; address/data are forced to zero when not requesting.
  assign m_valid = (state == ST_ISSUE);
  assign m_addr  = m_valid ? (TILE_BASE | {18'd0, cell_word(cell_x, cell_y), 2'b00}) : 32'd0;
  assign m_wdata = m_valid ? {26'd0, value} : 32'd0;
  assign m_wstrb = m_valid ? 4'b1111 : 4'b0000;

  // Registered vsync level for the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_q <= 1'b0;
    else       vs_q <= vs_act;
  end

  // State, cell counters and pending-abort flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cx         <= 7'd0;
      cy         <= 7'd0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      cx         <= cx_nxt;
      cy         <= cy_nxt;
      abort_pend <= abort_pend_nxt;
    end
  end

  // Next-state logic, row-major cell walk and status set pulses.
  always_comb begin
    state_nxt      = state;
    cx_nxt         = cx;
    cy_nxt         = cy;
    abort_pend_nxt = abort_pend;
    done_set       = 1'b0;
    aborted_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        abort_pend_nxt = 1'b0;
        if (start_req) begin
          cx_nxt = 7'd0;
          cy_nxt = 7'd0;
          if ((rect.w == 7'd0) || (rect.h == 7'd0)) state_nxt = ST_FINISH;
          else if (wait_vsync_eff)                  state_nxt = ST_WAIT_VS;
          else                                      state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT_VS: begin
        if (abort_req) begin
          abort_pend_nxt = 1'b1;
          state_nxt      = ST_FINISH;
        end else if (vs_edge) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // An abort is remembered but the outstanding request is held
        // until the responder takes it.
        if (abort_req) abort_pend_nxt = 1'b1;
        if (m_ready) begin
          if (abort_req || abort_pend) begin
            state_nxt = ST_FINISH;
          end else if (cx_last) begin
            cx_nxt = 7'd0;
            if (cy_last) state_nxt = ST_FINISH;
            else         cy_nxt    = cy + 7'd1;
          end else begin
            cx_nxt = cx + 7'd1;
          end
        end
      end
      ST_FINISH: begin
        done_set       = 1'b1;
        aborted_set    = abort_pend;
        abort_pend_nxt = 1'b0;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tile_fill_engine.sv
// tb_tile_fill_engine: directed register vectors from a table plus
// hand-written fill sequences for the tile fill engine.
module tb_tile_fill_engine;
  import tile_fill_engine_pkg::*;

  localparam logic [31:0] CFG_BASE  = 32'h0540_0000;
  localparam logic [31:0] TILE_BASE = 32'h0520_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_addr = 32'd0;
  logic [3:0]  cfg_wstrb = 4'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        cfg_ready;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        vsync = 1'b1;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } xfer_t;
  xfer_t xq[$];

  typedef struct {
    logic [1:0]  idx;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        do_chk;
    logic [31:0] exp;
    string       name;
  } reg_vec_t;
  reg_vec_t vecs[$];

  int   rdy_mode = 0;
  int   rdy_dly = 0;
  logic man_rdy = 1'b0;
  int   wait_cnt = 0;

  logic        stall_q = 1'b0;
  logic [31:0] p_addr = 32'd0;
  logic [31:0] p_data = 32'd0;
  int          stall_viol = 0;
  int          stall_cycles = 0;

  always #5 clk = ~clk;

  tile_fill_engine #(
    .CFG_BASE(CFG_BASE),
    .TILE_BASE(TILE_BASE),
    .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_addr (cfg_addr),
    .cfg_wstrb(cfg_wstrb),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .cfg_ready(cfg_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .vsync    (vsync),
    .irq      (irq)
  );

  // Video-side responder: 0 = follow man_rdy, 1 = always ready,
  // 2 = raise ready rdy_dly cycles into each request, drop after acceptance.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: m_ready = man_rdy;
        1: m_ready = 1'b1;
        default: begin
          if (m_ready) begin
            m_ready  = 1'b0;
            wait_cnt = 0;
          end else if (m_valid) begin
            wait_cnt++;
            if (wait_cnt >= rdy_dly) m_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Transfer log and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) xq.push_back({m_addr, m_wdata, m_wstrb});
    if (!reset && m_valid && stall_q && (m_addr !== p_addr || m_wdata !== p_data))
      stall_viol++;
    stall_q = !reset && m_valid && !m_ready;
    if (stall_q) stall_cycles++;
    p_addr = m_addr;
    p_data = m_wdata;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_xfer(input logic [1:0] idx, input logic [3:0] strb,
                          input logic [31:0] wd, output logic [31:0] rd);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_addr  = CFG_BASE | {28'd0, idx, 2'b00};
    cfg_wstrb = strb;
    cfg_wdata = wd;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cfg_ready && n < 8);
    chk("cfg_ack", {31'd0, cfg_ready}, 32'd1);
    rd = cfg_rdata;
    cfg_valid = 1'b0;
    cfg_wstrb = 4'd0;
    cfg_wdata = 32'd0;
    cfg_addr  = 32'd0;
  endtask

  task automatic cfg_wr(input logic [1:0] idx, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] rd;
    cfg_xfer(idx, strb, wd, rd);
  endtask

  task automatic cfg_rd_chk(input logic [1:0] idx, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    cfg_xfer(idx, 4'd0, 32'd0, rd);
    chk(name, rd, exp);
  endtask

  task automatic wait_irq(input int budget, input string name);
    int n;
    n = 0;
    while (!irq && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_done_in_budget"}, {31'd0, irq}, 32'd1);
  endtask

  function automatic logic [31:0] xa(input int k);
    return (k < xq.size()) ? xq[k].a : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] xd(input int k);
    return (k < xq.size()) ? xq[k].d : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] xs(input int k);
    return (k < xq.size()) ? {28'd0, xq[k].s} : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [31:0] exp_a[6];
    int n0, sv0, sc0, cnt;

    // Register table: idx, strb, wdata (strb 0 = read), check flag, expected, name.
    vecs.push_back('{REG_CTRL,   4'h0, 32'h0,         1'b1, 32'h0,         "rd_ctrl_rst"});
    vecs.push_back('{REG_RECT,   4'h0, 32'h0,         1'b1, 32'h0,         "rd_rect_rst"});
    vecs.push_back('{REG_VALUE,  4'h0, 32'h0,         1'b1, 32'h0,         "rd_value_rst"});
    vecs.push_back('{REG_STATUS, 4'h0, 32'h0,         1'b1, 32'h0,         "rd_status_rst"});
    vecs.push_back('{REG_RECT,   4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,         "wr_rect_all"});
    vecs.push_back('{REG_RECT,   4'h0, 32'h0,         1'b1, 32'h7F7F_3F3F, "rd_rect_mask"});
    vecs.push_back('{REG_RECT,   4'h1, 32'h0,         1'b0, 32'h0,         "wr_rect_b0"});
    vecs.push_back('{REG_RECT,   4'h0, 32'h0,         1'b1, 32'h7F7F_3F00, "rd_rect_b0"});
    vecs.push_back('{REG_RECT,   4'h8, 32'h0500_0000, 1'b0, 32'h0,         "wr_rect_b3"});
    vecs.push_back('{REG_RECT,   4'h0, 32'h0,         1'b1, 32'h057F_3F00, "rd_rect_b3"});
    vecs.push_back('{REG_VALUE,  4'hF, 32'hFFFF_FFEA, 1'b0, 32'h0,         "wr_value"});
    vecs.push_back('{REG_VALUE,  4'h0, 32'h0,         1'b1, 32'h0000_002A, "rd_value"});
    vecs.push_back('{REG_VALUE,  4'h2, 32'h0,         1'b0, 32'h0,         "wr_value_b1"});
    vecs.push_back('{REG_VALUE,  4'h0, 32'h0,         1'b1, 32'h0000_002A, "rd_value_b1"});
    vecs.push_back('{REG_CTRL,   4'h1, 32'h0000_0002, 1'b0, 32'h0,         "wr_ctrl_wvs"});
    vecs.push_back('{REG_CTRL,   4'h0, 32'h0,         1'b1, 32'h0000_0002, "rd_ctrl_wvs"});
    vecs.push_back('{REG_CTRL,   4'h1, 32'h0,         1'b0, 32'h0,         "wr_ctrl_clr"});
    vecs.push_back('{REG_CTRL,   4'h0, 32'h0,         1'b1, 32'h0,         "rd_ctrl_clr"});
    vecs.push_back('{REG_STATUS, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,         "wr_status"});
    vecs.push_back('{REG_STATUS, 4'h0, 32'h0,         1'b1, 32'h0,         "rd_status_ro"});

    // Reset state.
    cycles(3);
    reset = 1'b0;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_cfg_rdata", cfg_rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    cycles(1);

    // Table-driven register accesses.
    foreach (vecs[i]) begin
      logic [31:0] rd;
      cfg_xfer(vecs[i].idx, vecs[i].strb, vecs[i].wdata, rd);
      if (vecs[i].do_chk) chk(vecs[i].name, rd, vecs[i].exp);
    end
    cycles(1);
    chk("cfg_ready_one_cycle", {31'd0, cfg_ready}, 32'd0);

    // Basic fill: x0=2 y0=3 2x2, value 5, always-ready responder.
    rdy_mode = 1;
    cfg_wr(REG_RECT, 4'hF, 32'h0202_0302);
    cfg_wr(REG_VALUE, 4'hF, 32'd5);
    n0 = xq.size();
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    chk("basic_valid_after_start", {31'd0, m_valid}, 32'd1);
    wait_irq(50, "basic");
    chk("basic_count", xq.size() - n0, 32'd4);
    exp_a[0] = 32'h0520_0308; exp_a[1] = 32'h0520_030C;
    exp_a[2] = 32'h0520_0408; exp_a[3] = 32'h0520_040C;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("basic_addr%0d", k), xa(n0 + k), exp_a[k]);
      chk($sformatf("basic_data%0d", k), xd(n0 + k), 32'd5);
      chk($sformatf("basic_strb%0d", k), xs(n0 + k), 32'hF);
    end
    cfg_rd_chk(REG_STATUS, 32'h2, "basic_status");
    chk("basic_irq", {31'd0, irq}, 32'd1);
    cfg_wr(REG_STATUS, 4'h1, 32'h2);
    cfg_rd_chk(REG_STATUS, 32'h0, "basic_status_clr");
    chk("basic_irq_clr", {31'd0, irq}, 32'd0);

    // Wrap at map edges with a slow responder.
    rdy_mode = 2;
    rdy_dly  = 3;
    cfg_wr(REG_RECT, 4'hF, 32'h0202_3F3F);
    cfg_wr(REG_VALUE, 4'hF, 32'h11);
    n0 = xq.size(); sv0 = stall_viol; sc0 = stall_cycles;
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    wait_irq(100, "wrap");
    chk("wrap_count", xq.size() - n0, 32'd4);
    exp_a[0] = 32'h0520_3FFC; exp_a[1] = 32'h0520_3F00;
    exp_a[2] = 32'h0520_00FC; exp_a[3] = 32'h0520_0000;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_addr%0d", k), xa(n0 + k), exp_a[k]);
      chk($sformatf("wrap_data%0d", k), xd(n0 + k), 32'h11);
    end
    chk("wrap_stalled", {31'd0, (stall_cycles - sc0) >= 8}, 32'd1);
    chk("wrap_stable", stall_viol - sv0, 32'd0);
    cfg_wr(REG_STATUS, 4'h1, 32'h2);

    // Vsync gating: single cell, edge 100 cycles after START.
    rdy_mode = 1;
    cfg_wr(REG_RECT, 4'hF, 32'h0101_0000);
    cfg_wr(REG_VALUE, 4'hF, 32'd7);
    n0 = xq.size();
    cfg_wr(REG_CTRL, 4'h1, 32'h3);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (m_valid) cnt++;
    end
    chk("vs_no_valid_before_edge", cnt, 32'd0);
    cfg_rd_chk(REG_STATUS, 32'h1, "vs_busy_waiting");
    vsync = 1'b0;
    #1;
    chk("vs_valid_at_edge", {31'd0, m_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("vs_valid_after_edge", {31'd0, m_valid}, 32'd1);
    wait_irq(20, "vs");
    vsync = 1'b1;
    chk("vs_count", xq.size() - n0, 32'd1);
    chk("vs_addr", xa(n0), 32'h0520_0000);
    chk("vs_data", xd(n0), 32'd7);
    cfg_wr(REG_CTRL, 4'h1, 32'h0);
    cfg_wr(REG_STATUS, 4'h1, 32'h2);

    // Abort while a request is stalled.
    rdy_mode = 0;
    man_rdy  = 1'b0;
    cfg_wr(REG_RECT, 4'hF, 32'h4040_0000);
    cfg_wr(REG_VALUE, 4'hF, 32'd3);
    n0 = xq.size(); sv0 = stall_viol;
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    cycles(3);
    cfg_wr(REG_CTRL, 4'h1, 32'h4);
    chk("abort_held_valid", {31'd0, m_valid}, 32'd1);
    chk("abort_no_xfer_yet", xq.size() - n0, 32'd0);
    chk("abort_stable", stall_viol - sv0, 32'd0);
    man_rdy = 1'b1;
    @(posedge clk);
    #1;
    man_rdy = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (m_valid) cnt++;
    end
    chk("abort_no_more_valid", cnt, 32'd0);
    chk("abort_count", xq.size() - n0, 32'd1);
    chk("abort_addr", xa(n0), 32'h0520_0000);
    chk("abort_data", xd(n0), 32'd3);
    cfg_rd_chk(REG_STATUS, 32'h6, "abort_status");
    cfg_wr(REG_STATUS, 4'h1, 32'h2);
    cfg_rd_chk(REG_STATUS, 32'h0, "abort_status_clr");

    // Zero-size fill.
    rdy_mode = 1;
    cfg_wr(REG_RECT, 4'hF, 32'h0500_0000);
    n0 = xq.size();
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    wait_irq(3, "zero");
    cycles(2);
    chk("zero_count", xq.size() - n0, 32'd0);
    cfg_wr(REG_STATUS, 4'h1, 32'h2);

    // Busy protection: VALUE/RECT writes and a second START mid-fill.
    rdy_mode = 2;
    rdy_dly  = 3;
    cfg_wr(REG_RECT, 4'hF, 32'h0203_140A);
    cfg_wr(REG_VALUE, 4'hF, 32'd4);
    n0 = xq.size();
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    cfg_wr(REG_VALUE, 4'hF, 32'd9);
    cfg_wr(REG_RECT, 4'hF, 32'hFFFF_FFFF);
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    wait_irq(200, "busy");
    cycles(20);
    chk("busy_count", xq.size() - n0, 32'd6);
    exp_a[0] = 32'h0520_1428; exp_a[1] = 32'h0520_142C; exp_a[2] = 32'h0520_1430;
    exp_a[3] = 32'h0520_1528; exp_a[4] = 32'h0520_152C; exp_a[5] = 32'h0520_1530;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("busy_addr%0d", k), xa(n0 + k), exp_a[k]);
      chk($sformatf("busy_data%0d", k), xd(n0 + k), 32'd4);
    end
    cfg_rd_chk(REG_VALUE, 32'd4, "busy_value_kept");
    cfg_rd_chk(REG_RECT, 32'h0203_140A, "busy_rect_kept");
    cfg_wr(REG_STATUS, 4'h1, 32'h2);

    // Asynchronous reset in the middle of a long fill.
    rdy_mode = 1;
    cfg_wr(REG_RECT, 4'hF, 32'h4040_0000);
    cfg_wr(REG_VALUE, 4'hF, 32'd1);
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    cycles(5);
    reset = 1'b1;
    #1;
    chk("rstmid_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rstmid_m_addr", m_addr, 32'd0);
    cycles(2);
    reset = 1'b0;
    n0 = xq.size();
    cfg_rd_chk(REG_STATUS, 32'h0, "rstmid_status");
    cycles(10);
    chk("rstmid_no_xfer", xq.size() - n0, 32'd0);
    cfg_wr(REG_RECT, 4'hF, 32'h0101_0105);
    cfg_wr(REG_VALUE, 4'hF, 32'd2);
    cfg_wr(REG_CTRL, 4'h1, 32'h1);
    wait_irq(20, "rstmid_restart");
    chk("rstmid_count", xq.size() - n0, 32'd1);
    chk("rstmid_addr", xa(n0), 32'h0520_0114);
    chk("rstmid_data", xd(n0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
